// File: rtl/regfile_wb_arbiter.sv
//------------------------------------------------------------------------------
// Module   : regfile_wb_arbiter
// Brief    : Register-file write-port arbiter merging pipeline WB results with
//            a FIFO of long-latency results; optional pending-write scoreboard
//            enabled by `define REGFILE_WB_SB_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module regfile_wb_arbiter #(
    parameter int LQ_DEPTH     = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        pipe_valid_i,
    input  logic [4:0]  pipe_rd_addr_i,
    input  logic [31:0] pipe_rd_wdata_i,
    input  logic        lu_valid_i,
    output logic        lu_ready_o,
    input  logic [4:0]  lu_rd_addr_i,
    input  logic [31:0] lu_rd_wdata_i,
    input  logic        issue_i,
    input  logic [4:0]  issue_rd_i,
    input  logic [4:0]  id_rs1_addr,
    input  logic [4:0]  id_rs2_addr,
    output logic        rs1_busy_o,
    output logic        rs2_busy_o,
    output logic        stall_pipe_o,
    output logic        wb_q_is_rd_write,
    output logic [4:0]  wb_rd_addr,
    output logic [31:0] wb_rd_wdata
);

    localparam int PTR_W = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] C_FULL      = CNT_W'(LQ_DEPTH);
    localparam logic [STV_W-1:0] C_STV_LIMIT = STV_W'(STARVE_LIMIT);

    logic [4:0]       lq_addr_q [LQ_DEPTH];
    logic [31:0]      lq_data_q [LQ_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [STV_W-1:0] starve_q, starve_d;
    logic             stall_q, stall_d;
    logic             wb_we_q, wb_we_d;
    logic [4:0]       wb_addr_q, wb_addr_d;
    logic [31:0]      wb_data_q, wb_data_d;

    logic        w_push, w_pop, w_pipe_wr, w_nonempty, w_head_wr;
    logic [4:0]  w_head_addr;
    logic [31:0] w_head_data;

    assign lu_ready_o  = (count_q != C_FULL);
    assign w_push      = lu_valid_i & lu_ready_o;
    assign w_pipe_wr   = pipe_valid_i & (pipe_rd_addr_i != 5'd0);
    assign w_nonempty  = (count_q != '0);
    assign w_pop       = w_nonempty & ~w_pipe_wr;
    assign w_head_addr = lq_addr_q[rd_ptr_q];
    assign w_head_data = lq_data_q[rd_ptr_q];
    // Popping a head entry targeting x0 retires it without a write.
    assign w_head_wr   = w_pop & (w_head_addr != 5'd0);

    always_comb begin
        wr_ptr_d  = w_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d  = w_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d   = count_q;
        if (w_push && !w_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!w_push && w_pop) begin
            count_d = count_q - CNT_W'(1);
        end

        starve_d = '0;
        if (w_nonempty && w_pipe_wr) begin
            starve_d = (starve_q == C_STV_LIMIT) ? starve_q : starve_q + STV_W'(1);
        end
        stall_d = (starve_d >= C_STV_LIMIT);

        wb_we_d   = w_pipe_wr | w_head_wr;
        wb_addr_d = wb_addr_q;
        wb_data_d = wb_data_q;
        if (w_pipe_wr) begin
            wb_addr_d = pipe_rd_addr_i;
            wb_data_d = pipe_rd_wdata_i;
        end else if (w_head_wr) begin
            wb_addr_d = w_head_addr;
            wb_data_d = w_head_data;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            lq_addr_q[wr_ptr_q] <= lu_rd_addr_i;
            lq_data_q[wr_ptr_q] <= lu_rd_wdata_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            starve_q  <= '0;
            stall_q   <= 1'b0;
            wb_we_q   <= 1'b0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            starve_q  <= starve_d;
            stall_q   <= stall_d;
            wb_we_q   <= wb_we_d;
            wb_addr_q <= wb_addr_d;
            wb_data_q <= wb_data_d;
        end
    end

    assign stall_pipe_o     = stall_q;
    assign wb_q_is_rd_write = wb_we_q;
    assign wb_rd_addr       = wb_addr_q;
    assign wb_rd_wdata      = wb_data_q;

`ifdef REGFILE_WB_SB_EN
    logic [31:0] sb_q, sb_d;

    // Set is applied after clear so a same-cycle reissue keeps the bit.
    always_comb begin
        sb_d = sb_q;
        if (w_head_wr) begin
            sb_d[w_head_addr] = 1'b0;
        end
        if (issue_i && (issue_rd_i != 5'd0)) begin
            sb_d[issue_rd_i] = 1'b1;
        end
        sb_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sb_q <= '0;
        end else begin
            sb_q <= sb_d;
        end
    end

    assign rs1_busy_o = sb_q[id_rs1_addr];
    assign rs2_busy_o = sb_q[id_rs2_addr];

`ifdef RISCV_FORMAL
    a_issue_not_busy: assert property (@(posedge clk_i) disable iff (rst_i)
        (issue_i && issue_rd_i != 5'd0) |->
        (!sb_q[issue_rd_i] || (w_head_wr && w_head_addr == issue_rd_i)));
`endif
`else
    logic w_unused_sb;
    assign w_unused_sb = ^{issue_i, issue_rd_i, id_rs1_addr, id_rs2_addr};
    assign rs1_busy_o  = 1'b0;
    assign rs2_busy_o  = 1'b0;
`endif

`ifdef RISCV_FORMAL
    a_no_write_x0: assert property (@(posedge clk_i) disable iff (rst_i)
        wb_we_q |-> (wb_addr_q != 5'd0));
    a_no_push_full: assert property (@(posedge clk_i) disable iff (rst_i)
        w_push |-> (count_q != C_FULL));
    a_count_range: assert property (@(posedge clk_i) disable iff (rst_i)
        count_q <= C_FULL);
`endif

endmodule

`default_nettype wire
